id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the 5-stage core, with load-use hazard detection. It captures decoded operands, register indices and control bits from decode and presents them to execute, where the forwarding unit consumes `ex_rs1` and `ex_rs2`. It inserts a one-cycle bubble on a load-use dependence, holds on a downstream stall, squashes on a branch flush, and counts inserted bubbles.

## Interface
- `XLEN`, default 32: data and PC width.
- `CTRL_W`, default 11: control bus width; bit map comes from the shared package.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: decode holds a real instruction.
- `id_pc` in XLEN: instruction PC.
- `id_rs1_data`, `id_rs2_data` in XLEN: register file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in 5: register indices.
- `id_uses_rs1`, `id_uses_rs2` in 1: instruction actually reads that source.
- `id_ctrl` in CTRL_W: decoded control bits.
- `flush` in 1: branch/jump resolved taken in EX; kill the decode instruction.
- `ex_stall` in 1: downstream multi-cycle hold (memory wait).
- `ex_valid`, `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`, `ex_rs1`, `ex_rs2`, `ex_rd`, `ex_ctrl` out: registered EX-stage copies.
- `pc_write_en` out 1: PC may advance.
- `if_id_write_en` out 1: IF/ID register may load.
- `bubble_count` out CNT_W: number of load-use bubbles inserted since reset.

## Operation
- `load_use` = `ex_valid` & `ex_ctrl[CTRL_MEMREAD]` & `ex_rd`≠0 & `id_valid` & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- Each cycle, take the first action whose condition holds:
  1. `rst`: all `ex_*` outputs become 0; `bubble_count` becomes 0.
  2. `ex_stall`: all `ex_*` registers hold their value; `flush` and `load_use` are ignored this cycle.
  3. `flush`: load a bubble.
  4. `load_use`: load a bubble; `bubble_count` increments, saturating at all-ones.
  5. Otherwise: load every `id_*` field; `ex_valid` = `id_valid`.
- Bubble: `ex_valid`=0 and `ex_ctrl`=0. `ex_rd`, `ex_rs1` and `ex_rs2` are 0, so forwarding never matches a bubble. All data fields are 0.
- `pc_write_en` = `if_id_write_en` = ~(`ex_stall` | (`load_use` & ~`flush`)).
- Flush together with load-use: the flush wins. There is no hold and no count, because the dependent instruction is itself being killed.
- No FSM is needed. The only state is the pipeline register plus the counter; the bubble lasts exactly one cycle because the bubble clears `ex_valid`, which drops `load_use`.

## Timing
- Register latency: 1 cycle from ID to EX.
- `load_use`, `pc_write_en` and `if_id_write_en` are combinational from the current `ex_*` state and the `id_*` inputs, valid within the same cycle.
- In reset (`rst` high): `pc_write_en`=1, `if_id_write_en`=1 (combinational, driven from the cleared state), `bubble_count`=0.
- Load-use sequence:
  - Cycle N: load is in EX, dependent instruction is in ID; the block stalls the front end.
  - Cycle N+1: bubble is in EX, dependent instruction is still in ID; no stall.
  - Cycle N+2: dependent instruction is in EX, and the load's result is forwarded from WB.
- Reset asserted mid-stall: the next edge clears everything; upstream resumes the following cycle.
- `ex_stall` held for k cycles: the EX contents are unchanged for those k edges; the counter does not move.

## Structure
- Shared package `core_pkg` holds:
  - control bit indices: `CTRL_REGWRITE`=0, `CTRL_MEMREAD`=1, `CTRL_MEMWRITE`=2, `CTRL_MEMTOREG`=3, `CTRL_ALUSRC`=4, `CTRL_BRANCH`=5, `CTRL_JUMP`=6, `CTRL_ALUOP` bits [10:7];
  - `CTRL_W`=11;
  - `REG_ZERO`=5'd0.
- One natural sub-module, `hazard_detect`: the combinational `load_use` term and the write-enable outputs. The pipeline register and the counter stay in `id_ex_stage`.

## Test plan
- Normal flow: `id_pc`=0x100, `id_rd`=5, RegWrite set, no hazards → after one edge `ex_pc`=0x100, `ex_rd`=5, `ex_valid`=1; write enables stay 1.
- Load-use: EX holds a load with rd=7; ID has `id_rs2`=7 and `id_uses_rs2`=1 → same cycle both write enables are 0; next edge gives a bubble (`ex_ctrl`=0, `ex_rd`=0) and `bubble_count`=1; the edge after that loads the dependent instruction.
- No false stall: EX holds a load with rd=7; ID has `id_rs2`=7 but `id_uses_rs2`=0 → no bubble, `bubble_count` unchanged. A load with `ex_rd`=0 likewise produces no stall.
- Flush together with load-use → bubble loaded, write enables 1, `bubble_count` unchanged.
- `ex_stall` for 3 cycles while a load-use is pending → EX contents frozen for 3 edges, write enables 0, no count; the bubble is inserted on the first edge after `ex_stall` drops.
- Saturation and reset: with the counter preloaded to 0xFFFF, a further load-use leaves 0xFFFF; asserting `rst` mid-stall clears all outputs to 0 and the counter to 0 on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: control-bus bit map and architectural constants.
package core_pkg;

  localparam int unsigned CTRL_W = 11;

  localparam int unsigned CTRL_REGWRITE  = 0;
  localparam int unsigned CTRL_MEMREAD   = 1;
  localparam int unsigned CTRL_MEMWRITE  = 2;
  localparam int unsigned CTRL_MEMTOREG  = 3;
  localparam int unsigned CTRL_ALUSRC    = 4;
  localparam int unsigned CTRL_BRANCH    = 5;
  localparam int unsigned CTRL_JUMP      = 6;
  localparam int unsigned CTRL_ALUOP_LSB = 7;
  localparam int unsigned CTRL_ALUOP_MSB = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection and front-end write enables for the ID/EX boundary.
module hazard_detect
  import core_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       flush,
  input  logic       ex_stall,
  output logic       load_use,
  output logic       pc_write_en,
  output logic       if_id_write_en
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_valid && ex_memread && (ex_rd != REG_ZERO) && id_valid && (rs1_hit || rs2_hit);
    // A flushed dependent is being killed anyway, so it must not hold the front end.
    pc_write_en    = !(ex_stall || (load_use && !flush));
    if_id_write_en = pc_write_en;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall hold, flush squash
// and a saturating count of inserted bubbles.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = core_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .ex_valid       (valid_q),
    .ex_memread     (ctrl_q[CTRL_MEMREAD]),
    .ex_rd          (rd_q),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .load_use       (load_use),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en)
  );

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    if (!ex_stall) begin
      if (flush || load_use) begin
        // Bubble: zeroed indices keep the forwarding unit from matching it.
        valid_d    = 1'b0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_d      = REG_ZERO;
        rs2_d      = REG_ZERO;
        rd_d       = REG_ZERO;
        ctrl_d     = '0;
        if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        valid_d    = id_valid;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
        ctrl_d     = id_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= REG_ZERO;
      rs2_q      <= REG_ZERO;
      rd_q       <= REG_ZERO;
      ctrl_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rs1_data  = rs1_data_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_ctrl      = ctrl_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a 4-bit counter keeps the saturation case short.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 11;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CTRL_W-1:0] CtrlAlu  = 11'h001;
  localparam logic [CTRL_W-1:0] CtrlLoad = 11'h00B;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              pc_write_en, if_id_write_en;
  logic [CNT_W-1:0]  bubble_count;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ctrl        (id_ctrl),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .bubble_count   (bubble_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic [CTRL_W-1:0] ctrl);
    id_valid    = 1'b1;
    id_pc       = pc;
    id_rs1_data = pc ^ 32'hAAAA_0000;
    id_rs2_data = pc ^ 32'h5555_0000;
    id_imm      = pc + 32'd4;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_rd       = rd;
    id_ctrl     = ctrl;
  endtask

  task automatic check_we(input string tag, input logic exp);
    check({tag, "_pc_we"}, 64'(pc_write_en), 64'(exp));
    check({tag, "_ifid_we"}, 64'(if_id_write_en), 64'(exp));
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_ctrl"}, 64'(ex_ctrl), 64'd0);
    check({tag, "_rd"}, 64'(ex_rd), 64'd0);
    check({tag, "_rs1"}, 64'(ex_rs1), 64'd0);
    check({tag, "_pc"}, 64'(ex_pc), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    set_id(32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, '0);
    id_valid = 1'b0;
    tick();
    check_bubble("reset");
    check("reset_cnt", 64'(bubble_count), 64'd0);
    check_we("reset", 1'b1);
    rst = 1'b0;

    // Normal flow
    set_id(32'h100, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, CtrlAlu);
    #1 check_we("normal", 1'b1);
    tick();
    check("normal_pc", 64'(ex_pc), 64'h100);
    check("normal_rd", 64'(ex_rd), 64'd5);
    check("normal_valid", 64'(ex_valid), 64'd1);
    check("normal_ctrl", 64'(ex_ctrl), 64'(CtrlAlu));
    check("normal_rs1d", 64'(ex_rs1_data), 64'hAAAA_0100);
    check("normal_imm", 64'(ex_imm), 64'h104);

    // Load-use through rs2
    set_id(32'h104, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, CtrlLoad);
    tick();
    check("load_rd", 64'(ex_rd), 64'd7);
    set_id(32'h108, 5'd3, 5'd7, 1'b1, 1'b1, 5'd8, CtrlAlu);
    #1 check_we("lu", 1'b0);
    tick();
    check_bubble("lu_bub");
    check("lu_cnt", 64'(bubble_count), 64'd1);
    check_we("lu_after", 1'b1);
    tick();
    check("lu_dep_pc", 64'(ex_pc), 64'h108);
    check("lu_dep_rd", 64'(ex_rd), 64'd8);
    check("lu_dep_rs2", 64'(ex_rs2), 64'd7);

    // No false stall: rs2 matches but unused
    set_id(32'h10C, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, CtrlLoad);
    tick();
    set_id(32'h110, 5'd3, 5'd7, 1'b1, 1'b0, 5'd9, CtrlAlu);
    #1 check_we("nouse", 1'b1);
    tick();
    check("nouse_pc", 64'(ex_pc), 64'h110);
    check("nouse_cnt", 64'(bubble_count), 64'd1);

    // Load targeting x0 never stalls
    set_id(32'h114, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, CtrlLoad);
    tick();
    set_id(32'h118, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, CtrlAlu);
    #1 check_we("x0", 1'b1);
    tick();
    check("x0_pc", 64'(ex_pc), 64'h118);
    check("x0_cnt", 64'(bubble_count), 64'd1);

    // Flush wins over load-use
    set_id(32'h11C, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, CtrlLoad);
    tick();
    set_id(32'h120, 5'd7, 5'd0, 1'b1, 1'b0, 5'd11, CtrlAlu);
    flush = 1'b1;
    #1 check_we("flush", 1'b1);
    tick();
    flush = 1'b0;
    check_bubble("flush_bub");
    check("flush_cnt", 64'(bubble_count), 64'd1);

    // Stall for 3 cycles with load-use pending
    set_id(32'h124, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, CtrlLoad);
    tick();
    set_id(32'h128, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, CtrlAlu);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_we("stall", 1'b0);
      tick();
      check("stall_pc", 64'(ex_pc), 64'h124);
      check("stall_rd", 64'(ex_rd), 64'd7);
      check("stall_cnt", 64'(bubble_count), 64'd1);
    end
    ex_stall = 1'b0;
    #1 check_we("unstall", 1'b0);
    tick();
    check_bubble("unstall_bub");
    check("unstall_cnt", 64'(bubble_count), 64'd2);
    tick();
    check("unstall_dep_pc", 64'(ex_pc), 64'h128);

    // Drive counter to all-ones, then one more load-use must not wrap
    for (int i = 0; i < 14; i++) begin
      set_id(32'h300 + 32'(i * 8), 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, CtrlLoad);
      tick();
      set_id(32'h304 + 32'(i * 8), 5'd7, 5'd0, 1'b1, 1'b0, 5'd13, CtrlAlu);
      tick();
      if (i == 12) check("sat_full", 64'(bubble_count), 64'hF);
    end
    check("sat_hold", 64'(bubble_count), 64'hF);

    // Reset asserted mid-stall
    set_id(32'h200, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, CtrlLoad);
    tick();
    set_id(32'h204, 5'd7, 5'd0, 1'b1, 1'b0, 5'd14, CtrlAlu);
    ex_stall = 1'b1;
    tick();
    check("rststall_pc", 64'(ex_pc), 64'h200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex_stall = 1'b0;
    check_bubble("rst_mid");
    check("rst_mid_cnt", 64'(bubble_count), 64'd0);
    check("rst_mid_imm", 64'(ex_imm), 64'd0);
    #1 check_we("rst_resume", 1'b1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
